// File: rtl/bomb_pkg.sv
// Shared types for the bomb fuse manager: slot states, per-bomb record,
// explosion payload and the saturating-free live-count update helper.
package bomb_pkg;

   localparam int unsigned COORD_W = 8;
   localparam int unsigned FUSE_W  = 4;
   localparam int unsigned CNT_W   = 3;

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      ARMED   = 2'd1,
      PENDING = 2'd2
   } slot_state_t;

   typedef logic               owner_t;
   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      slot_state_t       state;
      owner_t            owner;
      coord_t            coord;
      logic [FUSE_W-1:0] fuse;
   } bomb_rec_t;

   typedef struct packed {
      owner_t owner;
      coord_t coord;
   } explode_t;

   localparam owner_t    OWNER_P1 = 1'b0;
   localparam owner_t    OWNER_P2 = 1'b1;
   localparam bomb_rec_t FREE_REC = '{state: FREE, owner: OWNER_P1, coord: '0, fuse: '0};

   // Simultaneous increment and decrement cancel out.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc,
                                                 input logic             dec);
      logic [CNT_W-1:0] res;
      res = cnt;
      if (inc && !dec)      res = cnt + CNT_W'(1);
      else if (!inc && dec) res = cnt - CNT_W'(1);
      return res;
   endfunction

endpackage

// File: rtl/bomb_fuse_manager_if.sv
// Placement, chain, explosion handshake and status signals between the
// bomb fuse manager (slave) and its controller/resolver side (master).
interface bomb_fuse_manager_if;

   logic                                  p1_set_bomb;
   bomb_pkg::coord_t                      p1_coordinate;
   logic                                  p2_set_bomb;
   bomb_pkg::coord_t                      p2_coordinate;
   logic                                  chain_valid;
   bomb_pkg::coord_t                      chain_coord;
   logic                                  explode_ready;
   logic                                  explode_valid;
   bomb_pkg::coord_t                      explode_coord;
   bomb_pkg::owner_t                      explode_owner;
   logic [bomb_pkg::CNT_W-1:0]            bomb_num_1;
   logic [bomb_pkg::CNT_W-1:0]            bomb_num_2;
   logic [1:0]                            place_reject;

   modport master (
      output p1_set_bomb, p1_coordinate, p2_set_bomb, p2_coordinate,
             chain_valid, chain_coord, explode_ready,
      input  explode_valid, explode_coord, explode_owner,
             bomb_num_1, bomb_num_2, place_reject
   );

   modport slave (
      input  p1_set_bomb, p1_coordinate, p2_set_bomb, p2_coordinate,
             chain_valid, chain_coord, explode_ready,
      output explode_valid, explode_coord, explode_owner,
             bomb_num_1, bomb_num_2, place_reject
   );

endinterface

// File: rtl/bomb_slot.sv
// One bomb pool entry: FREE/ARMED/PENDING state, fuse countdown, and the
// coordinate compares used for placement conflicts and chain detonation.
module bomb_slot
   import bomb_pkg::*;
#(
   parameter int unsigned FUSE_TICKS = 3
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_tick,
   input  logic   i_alloc,
   input  owner_t i_alloc_owner,
   input  coord_t i_alloc_coord,
   input  logic   i_chain_valid,
   input  coord_t i_chain_coord,
   input  logic   i_release,
   input  coord_t i_p1_coord,
   input  coord_t i_p2_coord,
   output logic   o_live_c,
   output logic   o_pending_c,
   output logic   o_match_p1_c,
   output logic   o_match_p2_c,
   output owner_t o_owner,
   output coord_t o_coord
);

   bomb_rec_t r_rec;
   bomb_rec_t w_rec_nxt;
   logic      w_chain_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rec <= FREE_REC;
      else        r_rec <= w_rec_nxt;
   end

   // A chain hit and fuse expiry both land in PENDING; PENDING waits only for release.
   always_comb begin
      w_rec_nxt   = r_rec;
      w_chain_hit = i_chain_valid && (i_chain_coord == r_rec.coord);
      unique case (r_rec.state)
         FREE: begin
            if (i_alloc) begin
               w_rec_nxt = '{state: ARMED, owner: i_alloc_owner,
                             coord: i_alloc_coord, fuse: FUSE_W'(FUSE_TICKS)};
            end
         end
         ARMED: begin
            if (w_chain_hit) begin
               w_rec_nxt.state = PENDING;
            end else if (i_tick) begin
               if (r_rec.fuse == FUSE_W'(1)) w_rec_nxt.state = PENDING;
               else                          w_rec_nxt.fuse  = r_rec.fuse - FUSE_W'(1);
            end
         end
         PENDING: begin
            if (i_release) w_rec_nxt = FREE_REC;
         end
         default: w_rec_nxt = FREE_REC;
      endcase
   end

   assign o_live_c     = (r_rec.state != FREE);
   assign o_pending_c  = (r_rec.state == PENDING);
   assign o_match_p1_c = o_live_c && (r_rec.coord == i_p1_coord);
   assign o_match_p2_c = o_live_c && (r_rec.coord == i_p2_coord);
   assign o_owner      = r_rec.owner;
   assign o_coord      = r_rec.coord;

endmodule

// File: rtl/bomb_fuse_manager.sv
// Bomb pool manager: fuse prescaler, two-player placement allocator, pending
// arbiter feeding a single explosion holding register, and live-bomb counters.
module bomb_fuse_manager
   import bomb_pkg::*;
#(
   parameter int unsigned N_SLOTS        = 8,
   parameter int unsigned FUSE_TICKS     = 3,
   parameter int unsigned TICK_CYCLES    = 25_000_000,
   parameter int unsigned MAX_PER_PLAYER = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   bomb_fuse_manager_if.slave  bus
);

   localparam int unsigned IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int unsigned PRESC_W = $clog2(TICK_CYCLES);

   logic [PRESC_W-1:0] r_presc;
   logic               w_tick;

   logic [N_SLOTS-1:0] w_live;
   logic [N_SLOTS-1:0] w_pend;
   logic [N_SLOTS-1:0] w_m1;
   logic [N_SLOTS-1:0] w_m2;
   owner_t             w_owner [N_SLOTS];
   coord_t             w_coord [N_SLOTS];

   logic [N_SLOTS-1:0] w_free;
   logic [N_SLOTS-1:0] w_free2;
   logic               w_p1_found;
   logic               w_p2_found;
   logic [IDX_W-1:0]   w_p1_idx;
   logic [IDX_W-1:0]   w_p2_idx;
   logic               w_p1_acc;
   logic               w_p2_acc;
   logic [N_SLOTS-1:0] w_alloc;
   logic [N_SLOTS-1:0] w_alloc_p2;
   logic               w_pend_any;
   logic [IDX_W-1:0]   w_pend_idx;
   logic [N_SLOTS-1:0] w_release;
   logic               w_hs;

   logic               r_xv;
   logic [IDX_W-1:0]   r_xslot;
   explode_t           r_x;
   logic [CNT_W-1:0]   r_cnt1;
   logic [CNT_W-1:0]   r_cnt2;
   logic [1:0]         r_rej;

   // Fuse tick prescaler
   assign w_tick = (r_presc == PRESC_W'(TICK_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + PRESC_W'(1);
   end

   genvar g;
   generate
      for (g = 0; g < int'(N_SLOTS); g++) begin : gen_slot
         bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) u_slot (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_tick        (w_tick),
            .i_alloc       (w_alloc[g]),
            .i_alloc_owner (w_alloc_p2[g] ? OWNER_P2 : OWNER_P1),
            .i_alloc_coord (w_alloc_p2[g] ? bus.p2_coordinate : bus.p1_coordinate),
            .i_chain_valid (bus.chain_valid),
            .i_chain_coord (bus.chain_coord),
            .i_release     (w_release[g]),
            .i_p1_coord    (bus.p1_coordinate),
            .i_p2_coord    (bus.p2_coordinate),
            .o_live_c      (w_live[g]),
            .o_pending_c   (w_pend[g]),
            .o_match_p1_c  (w_m1[g]),
            .o_match_p2_c  (w_m2[g]),
            .o_owner       (w_owner[g]),
            .o_coord       (w_coord[g])
         );
      end
   endgenerate

   assign w_hs = r_xv && bus.explode_ready;

   // p1 is granted first; p2 then sees p1's slot and coordinate as taken.
   always_comb begin
      w_free     = ~w_live;
      w_p1_found = 1'b0;
      w_p1_idx   = '0;
      for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
         if (w_free[i]) begin
            w_p1_found = 1'b1;
            w_p1_idx   = IDX_W'(i);
         end
      end
      w_p1_acc = bus.p1_set_bomb && !(|w_m1) && w_p1_found &&
                 (r_cnt1 < CNT_W'(MAX_PER_PLAYER));

      w_free2 = w_free;
      if (w_p1_acc) w_free2[w_p1_idx] = 1'b0;
      w_p2_found = 1'b0;
      w_p2_idx   = '0;
      for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
         if (w_free2[i]) begin
            w_p2_found = 1'b1;
            w_p2_idx   = IDX_W'(i);
         end
      end
      w_p2_acc = bus.p2_set_bomb && !(|w_m2) && w_p2_found &&
                 !(w_p1_acc && (bus.p1_coordinate == bus.p2_coordinate)) &&
                 (r_cnt2 < CNT_W'(MAX_PER_PLAYER));

      w_alloc    = '0;
      w_alloc_p2 = '0;
      if (w_p1_acc) w_alloc[w_p1_idx] = 1'b1;
      if (w_p2_acc) begin
         w_alloc[w_p2_idx]    = 1'b1;
         w_alloc_p2[w_p2_idx] = 1'b1;
      end

      w_pend_any = 1'b0;
      w_pend_idx = '0;
      for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
         if (w_pend[i]) begin
            w_pend_any = 1'b1;
            w_pend_idx = IDX_W'(i);
         end
      end

      w_release = '0;
      if (w_hs) w_release[r_xslot] = 1'b1;
   end

   // Holding register: refills only from empty, so throughput is one per two cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xv    <= 1'b0;
         r_xslot <= '0;
         r_x     <= '0;
      end else if (w_hs) begin
         r_xv <= 1'b0;
      end else if (!r_xv && w_pend_any) begin
         r_xv    <= 1'b1;
         r_xslot <= w_pend_idx;
         r_x     <= '{owner: w_owner[w_pend_idx], coord: w_coord[w_pend_idx]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt1 <= '0;
         r_cnt2 <= '0;
         r_rej  <= '0;
      end else begin
         r_cnt1 <= cnt_next(r_cnt1, w_p1_acc, w_hs && (r_x.owner == OWNER_P1));
         r_cnt2 <= cnt_next(r_cnt2, w_p2_acc, w_hs && (r_x.owner == OWNER_P2));
         r_rej  <= {bus.p2_set_bomb && !w_p2_acc, bus.p1_set_bomb && !w_p1_acc};
      end
   end

   assign bus.explode_valid = r_xv;
   assign bus.explode_coord = r_x.coord;
   assign bus.explode_owner = r_x.owner;
   assign bus.bomb_num_1    = r_cnt1;
   assign bus.bomb_num_2    = r_cnt2;
   assign bus.place_reject  = r_rej;

endmodule

// File: tb/tb_bomb_fuse_manager.sv
// Bench for bomb_fuse_manager: directed scenarios plus random traffic, checked
// against a deadline-based pool model and an explosion scoreboard.
module tb_bomb_fuse_manager;
   import bomb_pkg::*;

   localparam int N    = 8;
   localparam int FT   = 3;
   localparam int TC   = 4;
   localparam int MAXP = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bomb_fuse_manager_if bus ();

   bomb_fuse_manager #(
      .N_SLOTS(N), .FUSE_TICKS(FT), .TICK_CYCLES(TC), .MAX_PER_PLAYER(MAXP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0] coord;
      bit         owner;
   } exp_t;

   // Model: a bomb explodes once the global tick count reaches its deadline.
   bit         m_live [N];
   bit         m_pend [N];
   bit         m_own  [N];
   logic [7:0] m_crd  [N];
   int         m_dl   [N];
   bit         live0  [N];
   bit         pend0  [N];
   bit         m_hv;
   int         m_hslot;
   int         m_edges;
   bit [1:0]   m_rej;
   exp_t       sb_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit place(input bit who, input logic [7:0] c, input int tnow);
      int cnt  = 0;
      int slot = -1;
      for (int i = 0; i < N; i++) begin
         if (m_live[i]) begin
            if (m_crd[i] == c) return 1'b0;
            if (m_own[i] == who) cnt++;
         end else if (slot < 0) begin
            slot = i;
         end
      end
      if (slot < 0 || cnt >= MAXP) return 1'b0;
      m_live[slot] = 1'b1;
      m_pend[slot] = 1'b0;
      m_own[slot]  = who;
      m_crd[slot]  = c;
      m_dl[slot]   = tnow + FT;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int  tnow;
      bit  hs;
      bit  found;
      exp_t e;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_live[i] = 1'b0;
            m_pend[i] = 1'b0;
         end
         m_hv    = 1'b0;
         m_hslot = 0;
         m_edges = 0;
         m_rej   = 2'b00;
         sb_q.delete();
      end else begin
         m_edges++;
         tnow = m_edges / TC;
         hs   = m_hv && bus.explode_ready;
         for (int i = 0; i < N; i++) begin
            live0[i] = m_live[i];
            pend0[i] = m_pend[i];
         end
         for (int i = 0; i < N; i++) begin
            if (live0[i] && !pend0[i]) begin
               if (bus.chain_valid && bus.chain_coord == m_crd[i]) m_pend[i] = 1'b1;
               if (tnow >= m_dl[i]) m_pend[i] = 1'b1;
            end
         end
         if (!m_hv) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (pend0[i] && !found) begin
                  found   = 1'b1;
                  m_hv    = 1'b1;
                  m_hslot = i;
                  e.coord = m_crd[i];
                  e.owner = m_own[i];
                  sb_q.push_back(e);
               end
            end
         end
         m_rej = 2'b00;
         if (bus.p1_set_bomb && !place(1'b0, bus.p1_coordinate, tnow)) m_rej[0] = 1'b1;
         if (bus.p2_set_bomb && !place(1'b1, bus.p2_coordinate, tnow)) m_rej[1] = 1'b1;
         if (hs) begin
            m_live[m_hslot] = 1'b0;
            m_pend[m_hslot] = 1'b0;
            m_hv            = 1'b0;
         end
      end
   end

   // Monitor: per-cycle status compare plus scoreboard pop on each handshake.
   always @(negedge clk) begin
      int   c1;
      int   c2;
      exp_t e;
      c1 = 0;
      c2 = 0;
      for (int i = 0; i < N; i++) begin
         if (m_live[i]) begin
            if (m_own[i]) c2++;
            else          c1++;
         end
      end
      check("bomb_num_1", int'(bus.bomb_num_1), c1);
      check("bomb_num_2", int'(bus.bomb_num_2), c2);
      check("place_reject", int'(bus.place_reject), int'(m_rej));
      check("explode_valid", int'(bus.explode_valid), int'(m_hv));
      if (m_hv) begin
         check("explode_coord", int'(bus.explode_coord), int'(m_crd[m_hslot]));
         check("explode_owner", int'(bus.explode_owner), int'(m_own[m_hslot]));
      end
      if (rst_n && bus.explode_valid && bus.explode_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got explosion at 0x%0h expected none", bus.explode_coord);
         end else begin
            e = sb_q.pop_front();
            check("sb_coord", int'(bus.explode_coord), int'(e.coord));
            check("sb_owner", int'(bus.explode_owner), int'(e.owner));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.p1_set_bomb = 1'b0;
      bus.p2_set_bomb = 1'b0;
      bus.chain_valid = 1'b0;
   endtask

   task automatic set_p1(input logic [7:0] c);
      bus.p1_set_bomb   = 1'b1;
      bus.p1_coordinate = c;
   endtask

   task automatic set_p2(input logic [7:0] c);
      bus.p2_set_bomb   = 1'b1;
      bus.p2_coordinate = c;
   endtask

   task automatic wait_valid(input string nm, input int limit, output int k);
      k = 0;
      while (!bus.explode_valid && k < limit) begin
         step();
         k++;
      end
      if (!bus.explode_valid) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: explode_valid not seen within %0d cycles", nm, limit);
      end
   endtask

   initial begin
      int  k;
      bit  seen;
      bus.p1_set_bomb   = 1'b0;
      bus.p1_coordinate = 8'h00;
      bus.p2_set_bomb   = 1'b0;
      bus.p2_coordinate = 8'h00;
      bus.chain_valid   = 1'b0;
      bus.chain_coord   = 8'h00;
      bus.explode_ready = 1'b1;

      repeat (3) @(posedge clk);
      #2;
      check("rst_valid", int'(bus.explode_valid), 0);
      check("rst_num1", int'(bus.bomb_num_1), 0);
      check("rst_reject", int'(bus.place_reject), 0);
      rst_n = 1'b1;

      // Basic fuse
      set_p1(8'h11);
      step();
      idle_inputs();
      check("basic_num1", int'(bus.bomb_num_1), 1);
      wait_valid("basic_fuse", 30, k);
      check("basic_latency_ok", int'(k >= 8 && k <= 16), 1);
      check("basic_coord", int'(bus.explode_coord), 8'h11);
      step();
      step();
      check("basic_num1_after", int'(bus.bomb_num_1), 0);

      // Same-cycle conflict
      set_p1(8'h22);
      set_p2(8'h22);
      step();
      idle_inputs();
      check("conflict_reject", int'(bus.place_reject), 2);
      check("conflict_num1", int'(bus.bomb_num_1), 1);
      check("conflict_num2", int'(bus.bomb_num_2), 0);
      repeat (20) step();

      // Per-player limit and full pool, held live by backpressure
      bus.explode_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_p1(8'h40 + 8'(i));
         step();
      end
      idle_inputs();
      check("limit_reject", int'(bus.place_reject), 1);
      check("limit_num1", int'(bus.bomb_num_1), MAXP);
      for (int i = 0; i < 4; i++) begin
         set_p2(8'h50 + 8'(i));
         step();
      end
      idle_inputs();
      check("full_reject", int'(bus.place_reject), 2);
      check("full_num2", int'(bus.bomb_num_2), 3);
      bus.explode_ready = 1'b1;
      repeat (60) step();

      // Backpressure on two bombs expiring together
      bus.explode_ready = 1'b0;
      set_p1(8'h60);
      set_p2(8'h61);
      step();
      idle_inputs();
      wait_valid("bp_first", 20, k);
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_hold_valid", int'(bus.explode_valid), 1);
         check("bp_hold_coord", int'(bus.explode_coord), 8'h60);
      end
      bus.explode_ready = 1'b1;
      step();
      check("bp_num1_dec", int'(bus.bomb_num_1), 0);
      check("bp_num2_live", int'(bus.bomb_num_2), 1);
      step();
      check("bp_second_coord", int'(bus.explode_coord), 8'h61);
      step();
      check("bp_num2_dec", int'(bus.bomb_num_2), 0);

      // Chain detonation, chain on an empty cell, and chain racing a placement
      set_p1(8'h35);
      step();
      idle_inputs();
      bus.chain_valid = 1'b1;
      bus.chain_coord = 8'h35;
      step();
      idle_inputs();
      wait_valid("chain", 5, k);
      check("chain_latency_ok", int'(k <= 2), 1);
      check("chain_coord", int'(bus.explode_coord), 8'h35);
      repeat (4) step();
      bus.chain_valid = 1'b1;
      bus.chain_coord = 8'h36;
      step();
      idle_inputs();
      check("chain_empty_valid", int'(bus.explode_valid), 0);
      set_p1(8'h37);
      bus.chain_valid = 1'b1;
      bus.chain_coord = 8'h37;
      step();
      idle_inputs();
      step();
      step();
      check("chain_race_valid", int'(bus.explode_valid), 0);
      check("chain_race_num1", int'(bus.bomb_num_1), 1);
      repeat (20) step();

      // Random traffic on a small coordinate pool to force conflicts
      for (int c = 0; c < 1500; c++) begin
         bus.p1_set_bomb   = ($urandom_range(0, 3) == 0);
         bus.p1_coordinate = 8'h70 + 8'($urandom_range(0, 5));
         bus.p2_set_bomb   = ($urandom_range(0, 3) == 0);
         bus.p2_coordinate = 8'h70 + 8'($urandom_range(0, 5));
         bus.chain_valid   = ($urandom_range(0, 7) == 0);
         bus.chain_coord   = 8'h70 + 8'($urandom_range(0, 5));
         bus.explode_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      idle_inputs();
      bus.explode_ready = 1'b1;
      repeat (60) step();

      // Reset mid-run with an explosion on offer and three armed bombs
      bus.explode_ready = 1'b0;
      set_p1(8'h83);
      step();
      idle_inputs();
      wait_valid("rst_offer", 20, k);
      set_p2(8'h81);
      step();
      idle_inputs();
      set_p1(8'h80);
      step();
      idle_inputs();
      set_p2(8'h82);
      step();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check("midrst_valid", int'(bus.explode_valid), 0);
      check("midrst_num1", int'(bus.bomb_num_1), 0);
      check("midrst_num2", int'(bus.bomb_num_2), 0);
      check("midrst_reject", int'(bus.place_reject), 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      bus.explode_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 5 * FT * TC + 8; c++) begin
         step();
         if (bus.explode_valid) seen = 1'b1;
      end
      check("postrst_no_explosion", int'(seen), 0);
      check("sb_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
